nest_tracker: RTL
=================

// Module: nest_tracker
// PURPOSE
//  Registered, parametrised nest bookkeeping for the Frogger top row.
//  Each arrival of the frog in the goal row is checked against a
//  configurable nest mask and the nests already filled. The block flags a
//  successful nesting or a bad landing, counts filled nests, and holds a
//  level-win flag until the level controller acknowledges it.
//  Sits between the top-row point register and the game/level controller.
// PARAMETERS
//  WIDTH      8             columns in the goal row (bits of frog/nest vectors)
//  NEST_MASK  8'b0101_0101  1 = column is a nest; must be nonzero, WIDTH bits
//  CNT_W      $clog2(WIDTH+1)  localparam: width of nest_count
// PORTS
//  CLOCK_50       in   1        system clock, all state on rising edge
//  RESET_InLow    in   1        asynchronous reset, active low
//  frog_row       in   WIDTH    frog position in goal row (expected one-hot)
//  arrive_stb     in   1        1-cycle pulse: frog entered goal row this cycle
//  lose_in        in   1        1 = frog lost this cycle (dominates arrive_stb)
//  clear_in       in   1        synchronous clear (game over / new game)
//  level_ack      in   1        level controller accepts win; starts next level
//  nest_reg       out  WIDTH    filled-nest vector (drives row-7 background)
//  nest_count     out  CNT_W    number of filled nests
//  nested_pulse   out  1        1-cycle pulse: valid nesting recorded
//  fail_pulse     out  1        1-cycle pulse: bad landing (non-nest/occupied/not one-hot)
//  level_win      out  1        held high while all nests filled, until level_ack
// BEHAVIOUR
//  - Reset (RESET_InLow=0, async): state=PLAY; all outputs 0.
//  - All outputs registered; response appears 1 cycle after the arrive_stb edge.
//  - FSM states: PLAY, WIN.
//  - PLAY, on an edge with arrive_stb=1 and lose_in=0:
//      ok = onehot(frog_row) && |(frog_row & NEST_MASK & ~nest_reg)
//      ok:  nest_reg <= nest_reg | frog_row; nest_count++; nested_pulse <= 1.
//      !ok: nest_reg unchanged; fail_pulse <= 1.
//      If ok and (nest_reg | frog_row) == NEST_MASK: go to WIN, level_win <= 1,
//      in the same edge as nested_pulse.
//  - arrive_stb with lose_in=1: no update and no pulses (loss is handled upstream).
//  - frog_row == 0 or with >1 bit set counts as !ok (fail_pulse).
//  - nested_pulse and fail_pulse are low on every edge not described above;
//    they are never both high.
//  - WIN: arrive_stb is ignored; nest_reg and nest_count are held.
//    level_ack=1: nest_reg <= 0, nest_count <= 0, level_win <= 0, go to PLAY.
//    level_ack in PLAY has no effect.
//  - clear_in=1 (any state): nest_reg, nest_count, pulses and level_win <= 0;
//    state <= PLAY. clear_in overrides arrive_stb and level_ack on the same edge.
//  - nest_count never exceeds popcount(NEST_MASK); there is no wrap-around.
//  - Async reset mid-level discards all nests at once, with no pulse.
// TESTING (WIDTH=8, NEST_MASK=8'b0101_0101)
//  1. Reset, then arrive_stb with frog_row=8'h01, lose=0 -> next cycle
//     nest_reg=8'h01, count=1, nested_pulse=1 for 1 cycle.
//  2. Repeat frog_row=8'h01 -> fail_pulse=1; nest_reg stays 8'h01, count stays 1.
//     Then frog_row=8'h02 (non-nest) -> fail_pulse=1; nothing else changes.
//  3. Arrivals at 04, 10, 40 -> after the last one nest_reg=8'h55, count=4,
//     nested_pulse and level_win rise together; further arrivals ignored;
//     level_ack -> next cycle nest_reg=0, count=0, level_win=0.
//  4. arrive_stb and lose_in together (frog_row=8'h04) -> no pulse, nest_reg unchanged.
//     frog_row=8'h05 (two bits set) -> fail_pulse=1.
//  5. clear_in together with a valid arrival -> nest_reg=0, no pulse.
//     clear_in while in WIN -> level_win=0, back to PLAY.
//  6. Assert RESET_InLow=0 between clock edges with nest_reg=8'h11 -> outputs
//     go to 0 immediately (async); the next arrival behaves as after reset.

Source files
------------

// File: rtl/nest_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : nest_tracker
//  Description : Goal-row nest bookkeeping. Each frog arrival is checked
//                against the nest mask and the nests already filled. Flags a
//                good nesting or a bad landing, counts filled nests and holds
//                a level-win flag until the level controller acknowledges it.
//  Revision    : 1.0  initial release
// ============================================================================
module nest_tracker #(
   parameter  int               WIDTH     = 8,
   parameter  logic [WIDTH-1:0] NEST_MASK = 8'b0101_0101,
   localparam int               CNT_W     = $clog2(WIDTH + 1)
) (
   input  logic             CLOCK_50,
   input  logic             RESET_InLow,
   input  logic [WIDTH-1:0] frog_row,
   input  logic             arrive_stb,
   input  logic             lose_in,
   input  logic             clear_in,
   input  logic             level_ack,
   output logic [WIDTH-1:0] nest_reg,
   output logic [CNT_W-1:0] nest_count,
   output logic             nested_pulse,
   output logic             fail_pulse,
   output logic             level_win
);

   // Two-state controller: collecting nests, or waiting for the win to be acked.
   localparam logic [0:0] c_PLAY = 1'b0;
   localparam logic [0:0] c_WIN  = 1'b1;

   localparam logic [WIDTH-1:0] c_ONE_W = WIDTH'(1);
   localparam logic [CNT_W-1:0] c_ONE_C = CNT_W'(1);

   logic [0:0]       r_state;
   logic [WIDTH-1:0] r_nest;
   logic [CNT_W-1:0] r_count;
   logic             r_nested;
   logic             r_fail;
   logic             r_win;

   logic             w_onehot;
   logic             w_free_nest;
   logic             w_ok;
   logic             w_arrival;
   logic [WIDTH-1:0] w_nest_next;
   logic             w_full;

   // A landing is good only for a single-bit position on a still-empty nest.
   // x & (x-1) clears the lowest set bit, so it is zero exactly for 0 or one-hot.
   always_comb begin
      w_onehot    = (frog_row != '0) && ((frog_row & (frog_row - c_ONE_W)) == '0);
      w_free_nest = |(frog_row & NEST_MASK & ~r_nest);
      w_ok        = w_onehot && w_free_nest;
      w_arrival   = arrive_stb && !lose_in;
      w_nest_next = r_nest | frog_row;
      w_full      = (w_nest_next == NEST_MASK);
   end

   // Main state register: clear dominates, then per-state arrival/ack handling.
   // Pulses default low so they can only ever last one cycle. The count cannot
   // exceed the number of nests because it only grows on a newly filled nest.
   always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
      if (!RESET_InLow) begin
         r_state  <= c_PLAY;
         r_nest   <= '0;
         r_count  <= '0;
         r_nested <= 1'b0;
         r_fail   <= 1'b0;
         r_win    <= 1'b0;
      end else begin
         r_nested <= 1'b0;
         r_fail   <= 1'b0;
         if (clear_in) begin
            r_state <= c_PLAY;
            r_nest  <= '0;
            r_count <= '0;
            r_win   <= 1'b0;
         end else begin
            case (r_state)
               c_PLAY: begin
                  if (w_arrival) begin
                     if (w_ok) begin
                        r_nest   <= w_nest_next;
                        r_count  <= r_count + c_ONE_C;
                        r_nested <= 1'b1;
                        if (w_full) begin
                           r_state <= c_WIN;
                           r_win   <= 1'b1;
                        end
                     end else begin
                        r_fail <= 1'b1;
                     end
                  end
               end
               c_WIN: begin
                  if (level_ack) begin
                     r_state <= c_PLAY;
                     r_nest  <= '0;
                     r_count <= '0;
                     r_win   <= 1'b0;
                  end
               end
               default: begin
                  r_state <= c_PLAY;
               end
            endcase
         end
      end
   end

   // All outputs come straight from registers.
   always_comb begin
      nest_reg     = r_nest;
      nest_count   = r_count;
      nested_pulse = r_nested;
      fail_pulse   = r_fail;
      level_win    = r_win;
   end

endmodule
`default_nettype wire
